hex_scan_driver: RTL and testbench

- Downstream stage of the memory-mapped hex display controller.
- Takes the 16-bit latched hex value (4 nibbles) plus per-digit enable and blink masks.
- Time-multiplexes the value onto a 4-digit common-anode 7-segment display (Basys 3 style, active-low anodes and cathodes).
- Adds frame-coherent input sampling, anti-ghosting guard blanking and digit blinking.

---
 rtl/hex_scan_driver.sv | 130 +++++++++++++
 tb/tb_hex_scan_driver.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/hex_scan_driver.sv
// rtl/hex_scan_driver.sv - 4-digit multiplexed 7-segment scan driver with frame-coherent shadowing and blink
// Optional leading-zero blanking when HEX_SCAN_LZB_EN is defined.
module hex_scan_driver #(
    parameter int REFRESH_DIV = 100000,
    parameter int GUARD       = 16,
    parameter int BLINK_DIV   = 50000000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [15:0] digits_i,
    input  logic [3:0]  digit_en_i,
    input  logic [3:0]  blink_sel_i,
    output logic [3:0]  an_o,
    output logic [6:0]  seg_o,
    output logic        frame_o
);

    localparam int RW = $clog2(REFRESH_DIV);
    localparam int BW = $clog2(BLINK_DIV);

    logic [RW-1:0] refresh_cnt_q, refresh_cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_phase_q, blink_phase_d;
    logic [15:0]   shadow_digits_q, shadow_digits_d;
    logic [3:0]    shadow_en_q, shadow_en_d;
    logic [3:0]    shadow_blink_q, shadow_blink_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          frame_q, frame_d;

    logic          refresh_wrap;
    logic          frame_load;
    logic          visible;
    logic          lz_blank;
    logic [3:0]    nibble;

    function automatic logic [6:0] decode(input logic [3:0] n);
        case (n)
            4'h0: decode = 7'h40;
            4'h1: decode = 7'h79;
            4'h2: decode = 7'h24;
            4'h3: decode = 7'h30;
            4'h4: decode = 7'h19;
            4'h5: decode = 7'h12;
            4'h6: decode = 7'h02;
            4'h7: decode = 7'h78;
            4'h8: decode = 7'h00;
            4'h9: decode = 7'h10;
            4'hA: decode = 7'h08;
            4'hB: decode = 7'h03;
            4'hC: decode = 7'h46;
            4'hD: decode = 7'h21;
            4'hE: decode = 7'h06;
            default: decode = 7'h0E;
        endcase
    endfunction

    always_comb begin
        refresh_wrap    = (refresh_cnt_q == RW'(REFRESH_DIV - 1));
        refresh_cnt_d   = refresh_wrap ? '0 : refresh_cnt_q + 1'b1;
        idx_d           = refresh_wrap ? idx_q + 2'd1 : idx_q;
        // Inputs are only captured at the frame boundary so a mid-frame change never tears.
        frame_load      = refresh_wrap && (idx_q == 2'd3);
        frame_d         = frame_load;
        shadow_digits_d = frame_load ? digits_i    : shadow_digits_q;
        shadow_en_d     = frame_load ? digit_en_i  : shadow_en_q;
        shadow_blink_d  = frame_load ? blink_sel_i : shadow_blink_q;

        if (blink_cnt_q == BW'(BLINK_DIV - 1)) begin
            blink_cnt_d   = '0;
            blink_phase_d = ~blink_phase_q;
        end else begin
            blink_cnt_d   = blink_cnt_q + 1'b1;
            blink_phase_d = blink_phase_q;
        end

        nibble = shadow_digits_q[{idx_q, 2'b00} +: 4];
`ifdef HEX_SCAN_LZB_EN
        case (idx_q)
            2'd3:    lz_blank = (shadow_digits_q[15:12] == 4'h0);
            2'd2:    lz_blank = (shadow_digits_q[15:8] == 8'h00);
            2'd1:    lz_blank = (shadow_digits_q[15:4] == 12'h000);
            default: lz_blank = 1'b0;
        endcase
`else
        lz_blank = 1'b0;
`endif
        visible = shadow_en_q[idx_q] && (!shadow_blink_q[idx_q] || blink_phase_q) && !lz_blank;

        // Guard cycles at the start of each slot keep all anodes off to avoid ghosting.
        an_d  = 4'hF;
        seg_d = 7'h7F;
        if ((refresh_cnt_q >= RW'(GUARD)) && visible) begin
            an_d  = ~(4'b0001 << idx_q);
            seg_d = decode(nibble);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            refresh_cnt_q   <= '0;
            idx_q           <= 2'd0;
            blink_cnt_q     <= '0;
            blink_phase_q   <= 1'b1;
            shadow_digits_q <= 16'h0000;
            shadow_en_q     <= 4'h0;
            shadow_blink_q  <= 4'h0;
            an_q            <= 4'hF;
            seg_q           <= 7'h7F;
            frame_q         <= 1'b0;
        end else begin
            refresh_cnt_q   <= refresh_cnt_d;
            idx_q           <= idx_d;
            blink_cnt_q     <= blink_cnt_d;
            blink_phase_q   <= blink_phase_d;
            shadow_digits_q <= shadow_digits_d;
            shadow_en_q     <= shadow_en_d;
            shadow_blink_q  <= shadow_blink_d;
            an_q            <= an_d;
            seg_q           <= seg_d;
            frame_q         <= frame_d;
        end
    end

    assign an_o    = an_q;
    assign seg_o   = seg_q;
    assign frame_o = frame_q;

endmodule

// File: tb/tb_hex_scan_driver.sv
// tb/tb_hex_scan_driver.sv - randomized scoreboard bench for hex_scan_driver
module tb_hex_scan_driver;

    localparam int RDIV = 8;
    localparam int GRD  = 2;
    localparam int BDIV = 64;
`ifdef HEX_SCAN_LZB_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [15:0] digits_i = 16'h0;
    logic [3:0]  digit_en_i = 4'h0;
    logic [3:0]  blink_sel_i = 4'h0;
    logic [3:0]  an_o;
    logic [6:0]  seg_o;
    logic        frame_o;

    hex_scan_driver #(.REFRESH_DIV(RDIV), .GUARD(GRD), .BLINK_DIV(BDIV)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .digits_i(digits_i), .digit_en_i(digit_en_i),
        .blink_sel_i(blink_sel_i), .an_o(an_o), .seg_o(seg_o), .frame_o(frame_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int         n;
        logic [3:0] an;
        logic [6:0] seg;
        logic       frame;
    } exp_t;

    exp_t       sb[$];
    int         errors = 0;
    int         checks = 0;
    bit         active = 1'b0;
    int         n = 0;
    logic [15:0] m_dig = 16'h0;
    logic [3:0]  m_en = 4'h0;
    logic [3:0]  m_blk = 4'h0;
    logic [6:0]  seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Reference: everything derived from the edge count n since reset release.
    task automatic push_expected();
        exp_t e;
        int   slot_pos, idx;
        bit   phase, vis;
        int   nib;
        slot_pos = n % RDIV;
        idx      = (n / RDIV) % 4;
        phase    = ((n / BDIV) % 2) == 0;
        nib      = (m_dig >> (4 * idx)) & 'hF;
        vis      = m_en[idx] && (!m_blk[idx] || phase);
        if (LZB && idx > 0 && (m_dig >> (4 * idx)) == 0) vis = 1'b0;
        e.n = n;
        if (slot_pos < GRD || !vis) begin
            e.an  = 4'hF;
            e.seg = 7'h7F;
        end else begin
            e.an  = 4'hF ^ (4'd1 << idx);
            e.seg = seg_tab[nib];
        end
        e.frame = (n % (4 * RDIV)) == (4 * RDIV - 1);
        sb.push_back(e);
        if (e.frame) begin
            m_dig = digits_i;
            m_en  = digit_en_i;
            m_blk = blink_sel_i;
        end
    endtask

    task automatic run_cycles(input int k, input bit rnd);
        for (int i = 0; i < k; i++) begin
            if (rnd && $urandom_range(7) == 0) begin
                case ($urandom_range(3))
                    0: digits_i = 16'($urandom);
                    1: digits_i = 16'($urandom) & 16'h00FF;
                    2: digits_i = 16'($urandom) & 16'h000F;
                    default: digits_i = 16'($urandom) & 16'h0FFF;
                endcase
                digit_en_i  = 4'($urandom);
                blink_sel_i = 4'($urandom);
            end
            push_expected();
            @(negedge clk_i);
            n++;
        end
    endtask

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    task automatic restart();
        @(negedge clk_i);
        check("reset_an", int'(an_o), 4'hF);
        check("reset_seg", int'(seg_o), 7'h7F);
        check("reset_frame", int'(frame_o), 0);
        rst_i  = 1'b0;
        n      = 0;
        m_dig  = 16'h0;
        m_en   = 4'h0;
        m_blk  = 4'h0;
        active = 1'b1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk_i);
            #1;
            if (active) begin
                if (sb.size() == 0) begin
                    check("scoreboard_empty", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check($sformatf("an n=%0d", e.n), int'(an_o), int'(e.an));
                    check($sformatf("seg n=%0d", e.n), int'(seg_o), int'(e.seg));
                    check($sformatf("frame n=%0d", e.n), int'(frame_o), int'(e.frame));
                    check($sformatf("an_onehot n=%0d", e.n),
                          int'(an_o inside {4'hE, 4'hD, 4'hB, 4'h7, 4'hF}), 1);
                end
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk_i);
        restart();
        digits_i = 16'h1234; digit_en_i = 4'hF; blink_sel_i = 4'h0;
        run_cycles(80, 1'b0);
        digits_i = 16'hABCD;
        run_cycles(60, 1'b0);
        digit_en_i = 4'b0101;
        run_cycles(64, 1'b0);
        digit_en_i = 4'hF; blink_sel_i = 4'b0001;
        run_cycles(300, 1'b0);
        digits_i = 16'h0050; blink_sel_i = 4'h0;
        run_cycles(80, 1'b0);
        while ((n % (4 * RDIV)) != 20) run_cycles(1, 1'b0);
        active = 1'b0;
        #2;
        check("pre_reset_an", int'(an_o), 4'hB);
        rst_i = 1'b1;
        #1;
        check("async_reset_an", int'(an_o), 4'hF);
        check("async_reset_seg", int'(seg_o), 7'h7F);
        sb.delete();
        @(negedge clk_i);
        restart();
        run_cycles(1500, 1'b1);
        active = 1'b0;
        check("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
